q_update_engine: RTL
====================

Name: q_update_engine

Overview:
- Write-side counterpart of the policy path: the policy path reads Q rows to pick an action; this block takes a completed transition (state, one-hot action, reward, next state) and writes the temporal-difference-updated Q value back into the Q table.
- Does read-modify-write on one 64-bit Q row (4 actions x 16-bit signed) through a single-port synchronous RAM interface.
- Sits between the environment/reward logic and the Q-table RAM.

Parameters:
- ALPHA_SHIFT, 2, learning rate alpha = 2^-ALPHA_SHIFT (arithmetic right shift).
- GAMMA_SHIFT, 3, discount gamma = 1 - 2^-GAMMA_SHIFT.
- STATE_W, 6, state index width (64 states).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  transition present.
- in_ready  out  1  block can accept a transition; high only in IDLE.
- in_state  in  STATE_W  state s in which the action was taken.
- in_action  in  4  one-hot action a; bit i selects lane i.
- in_reward  in  16  signed reward r.
- in_next_state  in  STATE_W  resulting state s'.
- in_terminal  in  1  s' is terminal; max Q(s') is treated as 0.
- rd_en  out  1  RAM read strobe.
- rd_addr  out  STATE_W  RAM read row address.
- rd_data  in  64  RAM row; valid the cycle after rd_en; lane i = bits [16i+15:16i].
- wr_en  out  1  RAM write strobe (one cycle).
- wr_addr  out  STATE_W  RAM write row address.
- wr_data  out  64  full row to write.
- done  out  1  one-cycle pulse, coincident with wr_en or with an error abort.
- err  out  1  one-cycle pulse: in_action was not one-hot; no write performed.

Behaviour:
- Reset: state IDLE; in_ready=1; rd_en, wr_en, done, err = 0; rd_addr, wr_addr, wr_data = 0; captured registers cleared.
- FSM states: IDLE, RD_NEXT, RD_CUR, CALC, WRITE.
- IDLE: in_ready=1. When in_valid && in_ready, capture all in_* fields and go to RD_NEXT. If in_action is not one-hot (zero or multiple bits), pulse err and done next cycle, stay in IDLE, and do not write.
- RD_NEXT: if terminal, set max_next=0 and skip the read. Otherwise assert rd_en with rd_addr=s'. Go to RD_CUR.
- RD_CUR: if non-terminal, capture max_next = signed max of the 4 lanes of rd_data. Assert rd_en with rd_addr=s. Go to CALC.
- CALC: capture row_cur=rd_data and q_cur = lane a. Compute at 18-bit signed width:
  - target = r + max_next - (max_next >>> GAMMA_SHIFT)
  - delta = target - q_cur
  - q_new = q_cur + (delta >>> ALPHA_SHIFT)
  - Narrow q_new to 16 bits (see Optional Feature).
  - Go to WRITE.
- WRITE: wr_en=1, wr_addr=s, wr_data=row_cur with lane a replaced by q_new; all other lanes are unchanged bit-exactly. Pulse done. Return to IDLE.
- Latency: acceptance cycle T, read of s' at T+1, read of s at T+2, wr_en/done at T+4. Throughput is one transition per 5 cycles. in_ready is low from T+1 through T+4.
- Edge case s == s': handled naturally. Both reads return the pre-update row, and max_next uses old values.
- Reset mid-operation: reset returns to IDLE immediately. No wr_en is issued for the aborted transition, and no partial write occurs.
- in_valid while in_ready=0 is ignored; the upstream source must hold the transition until accepted.

Optional Feature:
- Macro: QUPD_SAT_EN.
- With QUPD_SAT_EN defined: q_new saturates to [-32768, 32767] (0x8000..0x7FFF).
- Without it: q_new is truncated to its low 16 bits (two's-complement wrap).

Test Plan:
- ALPHA_SHIFT=2, GAMMA_SHIFT=3; Q[5] lane1=0x0100; Q[9] lanes={0x0010,0x0200,0x0080,0xFFF0}; transition s=5, a=0010, r=64, s'=9 -> rd_addr 9 then 5; at T+4 wr_addr=5, lane1=0x0140, other lanes of Q[5] unchanged; done=1 for exactly one cycle.
- Terminal: s=3, a=1000, r=100, Q[3] lane3=0, in_terminal=1 -> no read of s'; lane3 written 0x0019.
- Saturation: q_cur=0x7F00, r=0x7FFF, max_next=0x7FFF -> with QUPD_SAT_EN lane written 0x7FFF; without it lane written 0x9B3F.
- Bad action: in_action=0000, then 0110 -> err and done pulse, wr_en stays 0, in_ready returns high the following cycle.
- Reset mid-op: assert rst_n=0 during CALC -> no wr_en; in_ready=1 after release; the next transition completes normally.
- Back-to-back: hold in_valid with two transitions -> second accepted 5 cycles after the first; in_ready low for 4 cycles between acceptances.

Source files
------------

// File: rtl/q_update_engine.sv
// Temporal-difference Q-row updater: reads Q(s') and Q(s), then writes back the row with lane a updated.
// Optional macro QUPD_SAT_EN saturates the updated lane; without it the lane wraps to 16 bits.
module q_update_engine #(
    parameter int ALPHA_SHIFT = 2,
    parameter int GAMMA_SHIFT = 3,
    parameter int STATE_W     = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    input  logic [3:0]         in_action,
    input  logic [15:0]        in_reward,
    input  logic [STATE_W-1:0] in_next_state,
    input  logic               in_terminal,
    output logic               rd_en,
    output logic [STATE_W-1:0] rd_addr,
    input  logic [63:0]        rd_data,
    output logic               wr_en,
    output logic [STATE_W-1:0] wr_addr,
    output logic [63:0]        wr_data,
    output logic               done,
    output logic               err
);

    typedef enum logic [2:0] {IDLE, RD_NEXT, RD_CUR, CALC, WRITE} state_t;

    state_t state, state_nx;

    logic [STATE_W-1:0] s_p0;
    logic [STATE_W-1:0] ns_p0;
    logic [3:0]         act_p0;
    logic signed [15:0] rew_p0;
    logic               term_p0;
    logic signed [15:0] max_next_p1;
    logic [63:0]        row_p2;
    logic               err_q;

    logic               accept;
    logic               onehot;
    logic signed [15:0] q_cur;
    logic signed [17:0] r18, mx18, q18, target, delta, qn18;
    logic signed [15:0] q_new;
    logic [63:0]        row_new;

    function automatic logic signed [15:0] lane_max(input logic [63:0] row);
        logic signed [15:0] m;
        logic signed [15:0] v;
        m = row[15:0];
        for (int i = 1; i < 4; i++) begin
            v = row[16*i +: 16];
            if (v > m) m = v;
        end
        return m;
    endfunction

    function automatic logic signed [15:0] narrow(input logic signed [17:0] v);
`ifdef QUPD_SAT_EN
        if (v > 18'sd32767)
            return 16'sh7FFF;
        else if (v < -18'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
`else
        return v[15:0];
`endif
    endfunction

    assign accept = in_valid && (state == IDLE);
    assign onehot = (in_action != 4'b0000) && ((in_action & (in_action - 4'd1)) == 4'b0000);

    // CALC stage: rd_data holds row s, max_next_p1 holds max Q(s')
    always_comb begin
        q_cur = '0;
        for (int i = 0; i < 4; i++) begin
            if (act_p0[i]) q_cur = rd_data[16*i +: 16];
        end
        r18    = {{2{rew_p0[15]}}, rew_p0};
        mx18   = {{2{max_next_p1[15]}}, max_next_p1};
        q18    = {{2{q_cur[15]}}, q_cur};
        target = r18 + mx18 - (mx18 >>> GAMMA_SHIFT);
        delta  = target - q18;
        qn18   = q18 + (delta >>> ALPHA_SHIFT);
        q_new  = narrow(qn18);
        row_new = rd_data;
        for (int i = 0; i < 4; i++) begin
            if (act_p0[i]) row_new[16*i +: 16] = q_new;
        end
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = ns_p0;
        wr_en    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept && onehot) state_nx = RD_NEXT;
            end
            RD_NEXT: begin
                rd_en    = !term_p0;
                state_nx = RD_CUR;
            end
            RD_CUR: begin
                rd_en    = 1'b1;
                rd_addr  = s_p0;
                state_nx = CALC;
            end
            CALC: state_nx = WRITE;
            WRITE: begin
                wr_en    = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign wr_addr = s_p0;
    assign wr_data = row_p2;
    assign err     = err_q;
    assign done    = wr_en | err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            s_p0        <= '0;
            ns_p0       <= '0;
            act_p0      <= '0;
            rew_p0      <= '0;
            term_p0     <= 1'b0;
            max_next_p1 <= '0;
            row_p2      <= '0;
            err_q       <= 1'b0;
        end else begin
            state <= state_nx;
            err_q <= accept && !onehot;
            if (accept) begin
                s_p0    <= in_state;
                ns_p0   <= in_next_state;
                act_p0  <= in_action;
                rew_p0  <= in_reward;
                term_p0 <= in_terminal;
            end
            // RD_NEXT / RD_CUR boundary: Q(s') arrives one cycle after its read
            if (state == RD_NEXT && term_p0) max_next_p1 <= '0;
            if (state == RD_CUR && !term_p0) max_next_p1 <= lane_max(rd_data);
            // CALC / WRITE boundary
            if (state == CALC) row_p2 <= row_new;
        end
    end

endmodule
